// File: rtl/stage_sum_reader_pkg.sv
// Shared constants and state encoding for the output shift register consumer chain.
// Reused by the shift register and the later feature/threshold stages.
package stage_sum_reader_pkg;

    localparam int INPUT_WIDTH = 37;
    localparam int REG_DEPTH   = 5;
    localparam int SUM_GUARD   = 3;
    localparam int SUM_WIDTH   = INPUT_WIDTH + SUM_GUARD;
    localparam int IDX_WIDTH   = 3;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = 3'(REG_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/stage_sum_reader_if.sv
// Stage-value input bus and valid/ready sum output of the stage sum reader.
// master drives stage values and out_ready; slave is the reader itself.
interface stage_sum_reader_if #(
    parameter int input_width = stage_sum_reader_pkg::INPUT_WIDTH,
    parameter int sum_width   = input_width + stage_sum_reader_pkg::SUM_GUARD
);

    logic                          data_valid_in;
    logic signed [input_width-1:0] din_stage1;
    logic signed [input_width-1:0] din_stage2;
    logic signed [input_width-1:0] din_stage3;
    logic signed [input_width-1:0] din_stage4;
    logic signed [input_width-1:0] din_stage5;
    logic                          out_ready;
    logic signed [sum_width-1:0]   sum_out;
    logic                          sum_valid;
    logic                          busy;
    logic                          overrun;

    modport master (
        output data_valid_in, din_stage1, din_stage2, din_stage3, din_stage4, din_stage5,
        output out_ready,
        input  sum_out, sum_valid, busy, overrun
    );

    modport slave (
        input  data_valid_in, din_stage1, din_stage2, din_stage3, din_stage4, din_stage5,
        input  out_ready,
        output sum_out, sum_valid, busy, overrun
    );

endinterface

// File: rtl/stage_sum_reader_rise_detect.sv
// Rising-edge detector on the shift register's level valid; free-running so a
// level held across a freeze still yields only one window.
module stage_sum_reader_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic dv_q_r;

    // Previous-cycle copy of the valid level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_q_r <= 1'b0;
        end else begin
            dv_q_r <= level;
        end
    end

    assign rise = level & ~dv_q_r;

endmodule

// File: rtl/stage_sum_reader.sv
// Snapshots the five stage outputs on a new window, sums them with one adder over
// five cycles and hands the windowed sum downstream via valid/ready.
module stage_sum_reader
    import stage_sum_reader_pkg::*;
#(
    parameter int input_width = INPUT_WIDTH,
    parameter int sum_width   = input_width + SUM_GUARD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    stage_sum_reader_if.slave    bus
);

    typedef logic signed [input_width-1:0] stage_t;
    typedef logic signed [sum_width-1:0]   sum_t;

    state_t               state_r;
    state_t               state_s;
    stage_t               snap_r [REG_DEPTH];
    stage_t               snap_s [REG_DEPTH];
    stage_t               din_s  [REG_DEPTH];
    sum_t                 acc_r;
    sum_t                 acc_s;
    sum_t                 term_s;
    logic [IDX_WIDTH-1:0] idx_r;
    logic [IDX_WIDTH-1:0] idx_s;
    sum_t                 sum_out_r;
    sum_t                 sum_out_s;
    logic                 sum_valid_r;
    logic                 sum_valid_s;
    logic                 busy_r;
    logic                 busy_s;
    logic                 overrun_r;
    logic                 overrun_s;
    logic                 dv_rise_s;
    logic                 transfer_s;

    function automatic sum_t sext(input stage_t v);
        return {{(sum_width - input_width){v[input_width-1]}}, v};
    endfunction

    stage_sum_reader_rise_detect u_rise_detect (
        .clk   (clk),
        .rst   (rst),
        .level (bus.data_valid_in),
        .rise  (dv_rise_s)
    );

    assign din_s[0] = bus.din_stage1;
    assign din_s[1] = bus.din_stage2;
    assign din_s[2] = bus.din_stage3;
    assign din_s[3] = bus.din_stage4;
    assign din_s[4] = bus.din_stage5;

    assign transfer_s = sum_valid_r & bus.out_ready & ~en;

    // Select the snapshot term addressed by idx, widened before it meets the accumulator.
    always_comb begin
        term_s = '0;
        case (idx_r)
            3'd0:    term_s = sext(snap_r[0]);
            3'd1:    term_s = sext(snap_r[1]);
            3'd2:    term_s = sext(snap_r[2]);
            3'd3:    term_s = sext(snap_r[3]);
            3'd4:    term_s = sext(snap_r[4]);
            default: term_s = '0;
        endcase
    end

    // Next-state and datapath updates; en high freezes everything and swallows rises.
    always_comb begin
        state_s     = state_r;
        snap_s      = snap_r;
        acc_s       = acc_r;
        idx_s       = idx_r;
        sum_out_s   = sum_out_r;
        sum_valid_s = sum_valid_r;
        overrun_s   = overrun_r;
        if (!en) begin
            case (state_r)
                IDLE: begin
                    if (dv_rise_s) begin
                        snap_s  = din_s;
                        acc_s   = '0;
                        idx_s   = '0;
                        state_s = ACCUM;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ACCUM: begin
                    if (dv_rise_s) begin
                        overrun_s = 1'b1;
                    end else begin
                        overrun_s = overrun_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        sum_out_s   = acc_r + term_s;
                        sum_valid_s = 1'b1;
                        state_s     = DONE;
                    end else begin
                        acc_s = acc_r + term_s;
                        idx_s = idx_r + 3'd1;
                    end
                end
                DONE: begin
                    if (transfer_s) begin
                        sum_valid_s = 1'b0;
                        // A window landing on the accepting edge starts straight away.
                        if (dv_rise_s) begin
                            snap_s  = din_s;
                            acc_s   = '0;
                            idx_s   = '0;
                            state_s = ACCUM;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        if (dv_rise_s) begin
                            overrun_s = 1'b1;
                        end else begin
                            overrun_s = overrun_r;
                        end
                    end
                end
                default: begin
                    state_s     = IDLE;
                    sum_valid_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        busy_s = (state_s != IDLE);
    end

    // State, snapshot, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            for (int i = 0; i < REG_DEPTH; i++) begin
                snap_r[i] <= '0;
            end
            acc_r       <= '0;
            idx_r       <= '0;
            sum_out_r   <= '0;
            sum_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            snap_r      <= snap_s;
            acc_r       <= acc_s;
            idx_r       <= idx_s;
            sum_out_r   <= sum_out_s;
            sum_valid_r <= sum_valid_s;
            busy_r      <= busy_s;
            overrun_r   <= overrun_s;
        end
    end

    assign bus.sum_out   = sum_out_r;
    assign bus.sum_valid = sum_valid_r;
    assign bus.busy      = busy_r;
    assign bus.overrun   = overrun_r;

endmodule
